clstm_sequencer: RTL and testbench

Control block that sequences the C-LSTM datapath: it walks the per-bank weight write enables for all three stages, admits input timesteps through a valid/ready handshake, waits for the datapath pipeline to drain, and then sweeps the 3×16 output select space to stream results out. It sits between the host/test harness and the datapath, owning every `wen_stage*`, input-valid and `data_sel*` signal the datapath consumes.

---
 rtl/clstm_ctrl_pkg.sv | 32 +++
 rtl/clstm_onehot_walker.sv | 35 +++
 rtl/clstm_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_clstm_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/clstm_ctrl_pkg.sv
// rtl/clstm_ctrl_pkg.sv - shared state type, default sizes and helpers for the C-LSTM sequencer
//
// Purpose: one place for the controller state encoding, the default
// bank/group/lane counts, the datapath pipeline latency and the
// timestep-count legality check.
package clstm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD1,
    ST_LOAD2,
    ST_LOAD3,
    ST_LOADED,
    ST_RUN,
    ST_DRAIN,
    ST_READOUT
  } state_e;

  localparam int DEF_N_S1     = 8;
  localparam int DEF_N_S2     = 7;
  localparam int DEF_N_S3     = 2;
  localparam int DEF_N_GRP    = 3;
  localparam int DEF_N_LANE   = 16;
  localparam int DEF_PIPE_LAT = 8;
  localparam int MAX_STEPS    = 16;

  // A run must contain between 1 and MAX_STEPS timesteps.
  function automatic logic steps_legal(input logic [4:0] n);
    return (n != 5'd0) && (n <= 5'(MAX_STEPS));
  endfunction

endpackage

// File: rtl/clstm_onehot_walker.sv
// rtl/clstm_onehot_walker.sv - one-hot write-enable walker for a single weight stage
//
// Purpose: on a go pulse, drives bit 0 of en the next cycle and shifts the
// single high bit up by one position per cycle until it falls off the top.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   go        - start pulse (sampled on the rising edge)
//   en        - registered one-hot enable, all zero when idle
//   last      - high while the top bit of en is active; chains the next stage
module clstm_onehot_walker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic [WIDTH-1:0] en,
  output logic             last
);

  logic [WIDTH-1:0] en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
    end else if (go) begin
      en_q <= WIDTH'(1);
    end else begin
      en_q <= en_q << 1;
    end
  end

  assign en   = en_q;
  assign last = en_q[WIDTH-1];

endmodule

// File: rtl/clstm_sequencer.sv
// rtl/clstm_sequencer.sv - C-LSTM datapath sequencer: weight load, timestep admission, drain and readout sweep
//
// Purpose: walks the per-bank weight write enables of the three stages,
// admits num_steps input timesteps, waits out the datapath latency and then
// sweeps the N_GRP x N_LANE output select space with a valid/ready handshake.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   cfg_start / cfg_busy     - weight load request / load in progress
//   wen_stage1..3            - one-hot bank write enables per stage
//   start_compute, num_steps - run request and its timestep count (1..16)
//   in_valid / in_ready      - input timestep handshake
//   dp_valid                 - one strobe to the datapath per accepted step
//   data_sel0 / data_sel1    - output group / lane select
//   out_valid / out_ready    - output word handshake
//   done                     - pulse after the final output word
//   cmd_err                  - sticky illegal-command flag
module clstm_sequencer
  import clstm_ctrl_pkg::*;
#(
  parameter int N_S1     = DEF_N_S1,
  parameter int N_S2     = DEF_N_S2,
  parameter int N_S3     = DEF_N_S3,
  parameter int N_GRP    = DEF_N_GRP,
  parameter int N_LANE   = DEF_N_LANE,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  output logic            cfg_busy,
  output logic [N_S1-1:0] wen_stage1,
  output logic [N_S2-1:0] wen_stage2,
  output logic [N_S3-1:0] wen_stage3,
  input  logic            start_compute,
  input  logic [4:0]      num_steps,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            dp_valid,
  output logic [2:0]      data_sel0,
  output logic [3:0]      data_sel1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            done,
  output logic            cmd_err
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  state_e        state_q;
  logic [4:0]    steps_q;
  logic [4:0]    step_cnt_q;
  logic [DW-1:0] drain_cnt_q;
  logic          busy_q;
  logic          in_ready_q;
  logic          dp_valid_q;
  logic          out_valid_q;
  logic          done_q;
  logic          cmd_err_q;
  logic [2:0]    sel0_q;
  logic [3:0]    sel1_q;

  logic last1, last2, last3;
  logic load_go, in_fire, out_fire, sweep_end;

  // A load may only start from a quiescent state; elsewhere cfg_start is ignored.
  assign load_go   = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_LOADED));
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid_q && out_ready;
  assign sweep_end = (sel0_q == 3'(N_GRP - 1)) && (sel1_q == 4'(N_LANE - 1));

  // Each stage starts the cycle after the previous stage's top bit, so the
  // three walks form one contiguous N_S1+N_S2+N_S3 cycle sequence.
  clstm_onehot_walker #(.WIDTH(N_S1)) u_walk_s1 (
    .clk (clk), .rst (rst), .go (load_go), .en (wen_stage1), .last (last1)
  );
  clstm_onehot_walker #(.WIDTH(N_S2)) u_walk_s2 (
    .clk (clk), .rst (rst), .go (last1), .en (wen_stage2), .last (last2)
  );
  clstm_onehot_walker #(.WIDTH(N_S3)) u_walk_s3 (
    .clk (clk), .rst (rst), .go (last2), .en (wen_stage3), .last (last3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      steps_q     <= '0;
      step_cnt_q  <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      dp_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      sel0_q      <= '0;
      sel1_q      <= '0;
    end else begin
      dp_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            state_q   <= ST_LOAD1;
            busy_q    <= 1'b1;
            cmd_err_q <= 1'b0;
          end else if (start_compute) begin
            cmd_err_q <= 1'b1;  // no weights loaded yet
          end
        end
        ST_LOAD1: if (last1) state_q <= ST_LOAD2;
        ST_LOAD2: if (last2) state_q <= ST_LOAD3;
        ST_LOAD3: begin
          if (last3) begin
            state_q <= ST_LOADED;
            busy_q  <= 1'b0;
          end
        end
        ST_LOADED: begin
          if (cfg_start) begin
            state_q   <= ST_LOAD1;
            busy_q    <= 1'b1;
            cmd_err_q <= 1'b0;
          end else if (start_compute) begin
            if (steps_legal(num_steps)) begin
              state_q    <= ST_RUN;
              steps_q    <= num_steps;
              step_cnt_q <= '0;
              in_ready_q <= 1'b1;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            dp_valid_q <= 1'b1;
            step_cnt_q <= step_cnt_q + 5'd1;
            if (step_cnt_q + 5'd1 == steps_q) begin
              in_ready_q  <= 1'b0;
              state_q     <= ST_DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
        ST_DRAIN: begin
          // The final dp_valid is high on entry; the results are stable
          // PIPE_LAT cycles later, and out_valid follows one cycle after that.
          if (drain_cnt_q == DW'(PIPE_LAT)) begin
            state_q     <= ST_READOUT;
            out_valid_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        ST_READOUT: begin
          if (out_fire) begin
            if (sweep_end) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              sel0_q      <= '0;
              sel1_q      <= '0;
              state_q     <= ST_LOADED;
            end else if (sel1_q == 4'(N_LANE - 1)) begin
              sel1_q <= '0;
              sel0_q <= sel0_q + 3'd1;
            end else begin
              sel1_q <= sel1_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_busy  = busy_q;
  assign in_ready  = in_ready_q;
  assign dp_valid  = dp_valid_q;
  assign data_sel0 = sel0_q;
  assign data_sel1 = sel1_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_clstm_sequencer.sv
// tb/tb_clstm_sequencer.sv - directed self-checking bench for clstm_sequencer
module tb_clstm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_busy;
  logic [7:0] wen_stage1;
  logic [6:0] wen_stage2;
  logic [1:0] wen_stage3;
  logic       start_compute;
  logic [4:0] num_steps;
  logic       in_valid;
  logic       in_ready;
  logic       dp_valid;
  logic [2:0] data_sel0;
  logic [3:0] data_sel1;
  logic       out_valid;
  logic       out_ready;
  logic       done;
  logic       cmd_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [29:0] all_outs;
  assign all_outs = {cfg_busy, wen_stage1, wen_stage2, wen_stage3, in_ready, dp_valid,
                     data_sel0, data_sel1, out_valid, done, cmd_err};

  always #5 clk = ~clk;

  clstm_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_busy      (cfg_busy),
    .wen_stage1    (wen_stage1),
    .wen_stage2    (wen_stage2),
    .wen_stage3    (wen_stage3),
    .start_compute (start_compute),
    .num_steps     (num_steps),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dp_valid      (dp_valid),
    .data_sel0     (data_sel0),
    .data_sel1     (data_sel1),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .done          (done),
    .cmd_err       (cmd_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int extra_dp;
    int k;
    int ndone;
    int nstrobe;
    logic [6:0] exp_idx;

    rst = 1'b1; cfg_start = 1'b0; start_compute = 1'b0; num_steps = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_val("reset_outs", 32'(all_outs), 32'h0);
    rst = 1'b0;
    tick();

    // start_compute before any load
    start_compute = 1'b1; num_steps = 5'd4;
    tick();
    start_compute = 1'b0;
    check_val("idle_cmd_err", 32'(cmd_err), 32'd1);
    check_val("idle_no_run", 32'({in_ready, dp_valid, cfg_busy}), 32'd0);
    tick();
    check_val("idle_no_dp", 32'(dp_valid), 32'd0);

    // full weight load: 17 contiguous one-hot cycles across the stages
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check_val("load_clr_err", 32'(cmd_err), 32'd0);
    for (int i = 0; i < 17; i++) begin
      check_val("wen_walk", 32'({wen_stage3, wen_stage2, wen_stage1}), 32'd1 << i);
      check_val("busy_walk", 32'(cfg_busy), 32'd1);
      tick();
    end
    check_val("busy_end", 32'(cfg_busy), 32'd0);
    check_val("wen_end", 32'({wen_stage3, wen_stage2, wen_stage1}), 32'd0);

    // num_steps = 0 is rejected
    start_compute = 1'b1; num_steps = 5'd0;
    tick();
    start_compute = 1'b0;
    check_val("zero_cmd_err", 32'(cmd_err), 32'd1);
    check_val("zero_no_ready", 32'(in_ready), 32'd0);
    tick();
    check_val("zero_no_dp", 32'(dp_valid), 32'd0);

    // cfg_start from LOADED clears the error and reloads
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check_val("reload_clr_err", 32'(cmd_err), 32'd0);
    check_val("reload_busy", 32'(cfg_busy), 32'd1);
    repeat (17) tick();
    check_val("reload_done", 32'(cfg_busy), 32'd0);

    // num_steps = 17 is rejected
    start_compute = 1'b1; num_steps = 5'd17;
    tick();
    start_compute = 1'b0;
    check_val("over_cmd_err", 32'(cmd_err), 32'd1);
    check_val("over_no_ready", 32'(in_ready), 32'd0);

    // run of 4 steps
    start_compute = 1'b1; num_steps = 5'd4;
    tick();
    start_compute = 1'b0;
    check_val("run_ready", 32'(in_ready), 32'd1);
    check_val("run_no_dp", 32'(dp_valid), 32'd0);
    check_val("run_err_sticky", 32'(cmd_err), 32'd1);
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_val("run_dp", 32'(dp_valid), 32'd1);
      check_val("run_ready_seq", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    lat = 0; extra_dp = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
      if (dp_valid) extra_dp++;
    end
    check_val("drain_latency", 32'(lat), 32'd9);
    check_val("drain_extra_dp", 32'(extra_dp), 32'd0);

    // readout with out_ready toggling
    out_ready = 1'b1; k = 0; ndone = 0;
    for (int c = 0; c < 200 && k < 48; c++) begin
      if (out_valid) begin
        exp_idx = {3'(k / 16), 4'(k % 16)};
        check_val("sweep_idx", 32'({data_sel0, data_sel1}), 32'(exp_idx));
        if (out_ready) k++;
      end
      tick();
      if (done) ndone++;
      out_ready = ~out_ready;
    end
    check_val("sweep_words", 32'(k), 32'd48);
    check_val("sweep_done", 32'(ndone), 32'd1);
    check_val("sweep_end_valid", 32'(out_valid), 32'd0);
    check_val("sweep_end_sel", 32'({data_sel0, data_sel1}), 32'd0);
    tick();
    check_val("done_once", 32'(done), 32'd0);

    // run of 16 steps, then reset in the middle of readout at (1,5)
    start_compute = 1'b1; num_steps = 5'd16;
    tick();
    start_compute = 1'b0;
    in_valid = 1'b1;
    nstrobe = 0;
    for (int c = 0; c < 40 && in_ready; c++) begin
      tick();
      if (dp_valid) nstrobe++;
    end
    in_valid = 1'b0;
    check_val("run16_strobes", 32'(nstrobe), 32'd16);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check_val("run16_latency", 32'(lat), 32'd9);
    out_ready = 1'b1;
    repeat (21) tick();
    check_val("mid_idx", 32'({data_sel0, data_sel1}), 32'({3'd1, 4'd5}));
    check_val("mid_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_outs", 32'(all_outs), 32'h0);
    tick();
    rst = 1'b0; out_ready = 1'b0;
    start_compute = 1'b1; num_steps = 5'd4;
    tick();
    start_compute = 1'b0;
    check_val("post_rst_cmd_err", 32'(cmd_err), 32'd1);
    check_val("post_rst_idle", 32'({in_ready, cfg_busy, done}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
